rr_weighted_arbiter: RTL and testbench

// Parametrised weighted round-robin arbiter with a valid/ready grant handshake.

---
 rtl/rr_weighted_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_weighted_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_weighted_arbiter.sv
// Weighted round-robin arbiter, registered grant with valid/ready accept.
// Ports: clk, nrst (async low), ena, req[W], weight[W*WW], lock, gnt_ready
//        -> gnt_valid, gnt_pos (one-hot), gnt_bin, gnt_last.
// Build option: define RR_ARB_LOCK_EN to make lock hold the current channel.
module rr_weighted_arbiter #(
  parameter int WIDTH    = 8,
  parameter int WIDTH_W  = $clog2(WIDTH),
  parameter int WEIGHT_W = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      ena,
  input  logic [WIDTH-1:0]          req,
  input  logic [WIDTH*WEIGHT_W-1:0] weight,
  input  logic                      lock,
  input  logic                      gnt_ready,
  output logic                      gnt_valid,
  output logic [WIDTH-1:0]          gnt_pos,
  output logic [WIDTH_W-1:0]        gnt_bin,
  output logic                      gnt_last
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH_W-1:0]  ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [WEIGHT_W-1:0] credit_dec;
  logic [WIDTH-1:0]    pos_d;
  logic [WIDTH_W-1:0]  bin_d;
  logic                last_d;

  logic [WIDTH_W-1:0]  base;
  logic                hit;
  logic [WIDTH_W-1:0]  pick;
  logic [WEIGHT_W-1:0] pick_w;
  logic [WEIGHT_W-1:0] load;
  logic                grab;
  logic                lock_hold;
  int                  k;

`ifdef RR_ARB_LOCK_EN
  assign lock_hold = lock & req[gnt_bin] & ena;
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign lock_hold   = 1'b0;
`endif

  // Search origin: the last served channel once a turn ends,
  // otherwise the stored pointer.
  assign base = (state_q == IDLE) ? ptr_q : gnt_bin;

  // Walk offsets high to low so the nearest requester after base wins.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    k    = 0;
    for (int i = WIDTH; i >= 1; i--) begin
      k = (int'(base) + i) % WIDTH;
      if (req[k]) begin
        hit  = 1'b1;
        pick = WIDTH_W'(k);
      end
    end
  end

  assign pick_w     = weight[pick*WEIGHT_W +: WEIGHT_W];
  assign load       = (pick_w == '0) ? WEIGHT_W'(1) : pick_w;
  assign credit_dec = credit_q - WEIGHT_W'(1);
  assign gnt_valid  = (state_q == GRANT);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    pos_d    = gnt_pos;
    bin_d    = gnt_bin;
    last_d   = gnt_last;
    grab     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ena && hit) grab = 1'b1;
      end
      GRANT: begin
        if (gnt_ready && !lock_hold) begin
          if (req[gnt_bin] && credit_dec != '0 && ena) begin
            credit_d = credit_dec;
            last_d   = (credit_dec == WEIGHT_W'(1));
          end else begin
            ptr_d = gnt_bin;
            if (ena && hit) begin
              grab = 1'b1;
            end else begin
              state_d  = IDLE;
              pos_d    = '0;
              bin_d    = '0;
              last_d   = 1'b0;
              credit_d = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (grab) begin
      state_d  = GRANT;
      pos_d    = {{(WIDTH-1){1'b0}}, 1'b1} << pick;
      bin_d    = pick;
      credit_d = load;
      last_d   = (load == WEIGHT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      ptr_q    <= WIDTH_W'(WIDTH - 1);
      credit_q <= '0;
      gnt_pos  <= '0;
      gnt_bin  <= '0;
      gnt_last <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      gnt_pos  <= pos_d;
      gnt_bin  <= bin_d;
      gnt_last <= last_d;
    end
  end

endmodule

// File: tb/tb_rr_weighted_arbiter.sv
// Randomised bench for rr_weighted_arbiter against a turn-level model.
// Directed scenarios first, then a long random run with sporadic resets.
module tb_rr_weighted_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        ena;
  logic [7:0]  req;
  logic [31:0] weight;
  logic        lock;
  logic        gnt_ready;
  logic        gnt_valid;
  logic [7:0]  gnt_pos;
  logic [2:0]  gnt_bin;
  logic        gnt_last;

  int n_cmp = 0;
  int n_err = 0;

`ifdef RR_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  rr_weighted_arbiter #(.WIDTH(8), .WEIGHT_W(4)) dut (
    .clk(clk), .nrst(nrst), .ena(ena), .req(req),
    .weight(weight), .lock(lock), .gnt_ready(gnt_ready),
    .gnt_valid(gnt_valid), .gnt_pos(gnt_pos),
    .gnt_bin(gnt_bin), .gnt_last(gnt_last)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: sim time exceeded, want finish");
    $fatal(1, "timeout");
  end

  // model: who holds the grant, grants left in its turn, last server
  bit m_valid;
  int m_ch;
  int m_credit;
  int m_ptr;

  task automatic model_reset();
    m_valid  = 1'b0;
    m_ch     = 0;
    m_credit = 0;
    m_ptr    = 7;
  endtask

  function automatic int w_of(int c);
    int w;
    w = int'(weight[c*4 +: 4]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int next_from(int from);
    for (int i = 1; i <= 8; i++)
      if (req[(from + i) % 8]) return (from + i) % 8;
    return -1;
  endfunction

  task automatic new_turn();
    m_ch     = next_from(m_ptr);
    m_credit = w_of(m_ch);
    m_valid  = 1'b1;
  endtask

  task automatic model_step();
    if (!nrst) begin
      model_reset();
    end else if (!m_valid) begin
      if (ena && req != 0) new_turn();
    end else if (gnt_ready) begin
      if (!(LOCK_ON && lock && req[m_ch] && ena)) begin
        m_credit--;
        if (!(req[m_ch] && m_credit > 0 && ena)) begin
          m_ptr = m_ch;
          if (ena && req != 0) new_turn();
          else m_valid = 1'b0;
        end
      end
    end
  endtask

  function automatic logic [7:0] m_pos();
    logic [7:0] p;
    p = '0;
    if (m_valid) p[m_ch] = 1'b1;
    return p;
  endfunction

  function automatic logic [2:0] m_bin();
    return m_valid ? 3'(m_ch) : 3'd0;
  endfunction

  function automatic logic m_last();
    return m_valid && (m_credit == 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    nrst      = 1'b0;
    ena       = 1'b1;
    req       = '0;
    weight    = 32'h1111_1111;
    lock      = 1'b0;
    gnt_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (gnt_valid !== 1'b0 || gnt_pos !== 8'h00 ||
        gnt_bin !== 3'd0 || gnt_last !== 1'b0) begin
      n_err++;
      $display("FAIL reset_vals: got v=%b p=%h b=%0d l=%b want 0",
               gnt_valid, gnt_pos, gnt_bin, gnt_last);
    end
    for (int c = 0; c < 100; c++) begin
      tick();
      n_cmp++;
      if (gnt_valid !== 1'b0 || gnt_pos !== 8'h00) begin
        n_err++;
        $display("FAIL idle_noreq c%0d: got v=%b p=%h want 0 00",
                 c, gnt_valid, gnt_pos);
      end
    end
  endtask

  task automatic test_rr_sweep();
    logic [2:0] eb;
    apply_reset();
    req       = 8'hFF;
    gnt_ready = 1'b1;
    for (int s = 0; s < 9; s++) begin
      tick();
      eb = 3'(s % 8);
      n_cmp++;
      if (gnt_valid !== 1'b1 || gnt_bin !== eb || gnt_bin !== m_bin()) begin
        n_err++;
        $display("FAIL sweep s%0d: got v=%b b=%0d want v=1 b=%0d",
                 s, gnt_valid, gnt_bin, eb);
      end
    end
  endtask

  task automatic test_weights();
    logic [2:0] eb [8];
    logic       el [8];
    eb = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd2, 3'd2, 3'd2};
    el = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset();
    weight    = 32'h1111_1311;
    req       = 8'h06;
    gnt_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      tick();
      n_cmp++;
      if (gnt_bin !== eb[s] || gnt_last !== el[s] ||
          gnt_last !== m_last()) begin
        n_err++;
        $display("FAIL weight s%0d: got b=%0d l=%b want b=%0d l=%b",
                 s, gnt_bin, gnt_last, eb[s], el[s]);
      end
    end
  endtask

  task automatic test_hold();
    apply_reset();
    req = 8'h20;
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b1 || gnt_pos !== 8'h20) begin
      n_err++;
      $display("FAIL hold_first: got v=%b p=%h want 1 20",
               gnt_valid, gnt_pos);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req    = 8'($urandom);
      ena    = 1'($urandom);
      weight = $urandom;
      tick();
      n_cmp++;
      if (gnt_valid !== 1'b1 || gnt_pos !== 8'h20 ||
          gnt_bin !== 3'd5 || gnt_pos !== m_pos()) begin
        n_err++;
        $display("FAIL hold c%0d: got v=%b p=%h b=%0d want 1 20 5",
                 c, gnt_valid, gnt_pos, gnt_bin);
      end
    end
    @(negedge clk);
    ena       = 1'b1;
    req       = 8'h00;
    gnt_ready = 1'b1;
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b0 || gnt_pos !== 8'h00 ||
        gnt_valid !== m_valid) begin
      n_err++;
      $display("FAIL hold_accept: got v=%b p=%h want 0 00",
               gnt_valid, gnt_pos);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    weight    = 32'h1111_4111;
    req       = 8'h08;
    gnt_ready = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++;
    if (gnt_bin !== 3'd3 || gnt_last !== 1'b0 || m_credit != 2) begin
      n_err++;
      $display("FAIL burst_pre: got b=%0d l=%b cr=%0d want 3 0 2",
               gnt_bin, gnt_last, m_credit);
    end
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (gnt_valid !== 1'b0 || gnt_pos !== 8'h00 ||
        gnt_bin !== 3'd0 || gnt_last !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst: got v=%b p=%h b=%0d l=%b want 0",
               gnt_valid, gnt_pos, gnt_bin, gnt_last);
    end
    @(negedge clk);
    nrst = 1'b1;
    req  = 8'h28;
    tick();
    n_cmp++;
    if (gnt_valid !== 1'b1 || gnt_bin !== 3'd3 || gnt_bin !== m_bin()) begin
      n_err++;
      $display("FAIL post_rst: got v=%b b=%0d want 1 3",
               gnt_valid, gnt_bin);
    end
  endtask

  task automatic test_lock();
    logic [2:0] eb;
    apply_reset();
    req       = 8'h81;
    lock      = 1'b1;
    gnt_ready = 1'b1;
    tick();
    n_cmp++;
    if (gnt_bin !== 3'd0) begin
      n_err++;
      $display("FAIL lock_first: got b=%0d want 0", gnt_bin);
    end
    for (int s = 0; s < 4; s++) begin
      tick();
      eb = LOCK_ON ? 3'd0 : ((s % 2 == 0) ? 3'd7 : 3'd0);
      n_cmp++;
      if (gnt_bin !== eb || gnt_bin !== m_bin()) begin
        n_err++;
        $display("FAIL lock s%0d: got b=%0d want %0d", s, gnt_bin, eb);
      end
    end
    @(negedge clk);
    lock = 1'b0;
    tick();
    n_cmp++;
    if (gnt_bin !== 3'd7 || gnt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL unlock: got v=%b b=%0d want 1 7",
               gnt_valid, gnt_bin);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      nrst = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 3) == 0)
        req = 8'($urandom);
      else if ($urandom_range(0, 3) == 0)
        req = 8'($urandom) & 8'($urandom) & 8'($urandom);
      ena       = ($urandom_range(0, 7) != 0);
      gnt_ready = ($urandom_range(0, 2) != 0);
      lock      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0)
        weight = $urandom & 32'h3333_3333;
      tick();
      n_cmp++;
      if (gnt_valid !== m_valid || gnt_pos !== m_pos() ||
          gnt_bin !== m_bin() || gnt_last !== m_last()) begin
        n_err++;
        $display("FAIL rand c%0d: got v=%b p=%h b=%0d l=%b want %b %h %0d %b",
                 c, gnt_valid, gnt_pos, gnt_bin, gnt_last,
                 m_valid, m_pos(), m_bin(), m_last());
      end
    end
  endtask

  initial begin
    nrst      = 1'b0;
    ena       = 1'b0;
    req       = '0;
    weight    = '0;
    lock      = 1'b0;
    gnt_ready = 1'b0;
    model_reset();
    test_reset();
    test_rr_sweep();
    test_weights();
    test_hold();
    test_async_reset();
    test_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
